// File: rtl/spmmio_xbar.sv
// Soft-CPU Wishbone MMIO crossbar: decodes the top address bits into one of NUM_CH channel strobes.
// Optional ack timeout with bus-error capture is enabled by defining SPMMIO_XBAR_TIMEOUT_EN.
module spmmio_xbar #(
  parameter int          NUM_CH         = 8,
  parameter int          DEC_BITS       = 8,
  parameter logic [15:0] CH_MASK        = 16'hFFFF,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [0:23]            adr_i,
  input  logic                   stb_i,
  input  logic                   cyc_i,
  input  logic [3:0]             sel_i,
  input  logic                   we_i,
  input  logic [31:0]            dat_i,
  output logic                   ack_o,
  output logic [31:0]            dat_o,
  output logic                   err_o,
  output logic [0:NUM_CH-1]      ch_stb_o,
  input  logic [NUM_CH-1:0]      ch_ack_i,
  input  logic [32*NUM_CH-1:0]   ch_dat_i,
  output logic [15:0]            err_count,
  output logic [0:23]            err_adr
);

  localparam int          IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] NUM_CH_U = NUM_CH;

  // S_IDLE: accept | S_BUSY: channel strobed, waiting for its ack | S_RESP: ack_o pulse
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic                 w_ack_nxt;
  logic [31:0]          w_dat_nxt;
  logic [0:NUM_CH-1]    w_stb_nxt;

  logic [DEC_BITS-1:0]  w_dec;
  logic [15:0]          w_mask_sh;
  logic                 w_mapped;
  logic                 w_sel_ack;
  logic [31:0]          w_sel_dat;

  // Address, sel, we and write data go to the slaves directly; only the index bits matter here.
  logic w_unused;
  assign w_unused = ^{sel_i, we_i, dat_i, adr_i};

  assign w_dec     = adr_i[0 +: DEC_BITS];
  assign w_mask_sh = CH_MASK >> w_dec;
  assign w_mapped  = ({{(32-DEC_BITS){1'b0}}, w_dec} < NUM_CH_U) && w_mask_sh[0];

  always_comb begin
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_ack = ch_ack_i[i];
        w_sel_dat = ch_dat_i[32*i +: 32];
      end
    end
  end

`ifdef SPMMIO_XBAR_TIMEOUT_EN
  localparam int             TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [0:23]      r_adr, w_adr_nxt;
  logic             w_err_nxt;
  logic [15:0]      w_cnt_nxt;
  logic [0:23]      w_eadr_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ack_nxt   = 1'b0;
    w_dat_nxt   = dat_o;
    w_stb_nxt   = ch_stb_o;
`ifdef SPMMIO_XBAR_TIMEOUT_EN
    w_timer_nxt = r_timer;
    w_adr_nxt   = r_adr;
    w_err_nxt   = 1'b0;
    w_cnt_nxt   = err_count;
    w_eadr_nxt  = err_adr;
`endif
    case (r_state)
      S_IDLE: begin
        if (cyc_i && stb_i) begin
          if (w_mapped) begin
            w_idx_nxt = w_dec[IDX_W-1:0];
            for (int i = 0; i < NUM_CH; i++) begin
              w_stb_nxt[i] = (w_dec[IDX_W-1:0] == IDX_W'(i));
            end
`ifdef SPMMIO_XBAR_TIMEOUT_EN
            w_timer_nxt = '0;
            w_adr_nxt   = adr_i;
`endif
            w_state_nxt = S_BUSY;
          end else begin
            w_dat_nxt   = '0;
            w_ack_nxt   = 1'b1;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_BUSY: begin
        if (!cyc_i) begin
          w_stb_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (w_sel_ack) begin
          // Slave ack takes priority over a timeout expiring in the same cycle.
          w_dat_nxt   = w_sel_dat;
          w_ack_nxt   = 1'b1;
          w_stb_nxt   = '0;
          w_state_nxt = S_RESP;
        end
`ifdef SPMMIO_XBAR_TIMEOUT_EN
        else if (r_timer == TMR_LAST) begin
          w_stb_nxt   = '0;
          w_dat_nxt   = ERR_DATA;
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
          w_eadr_nxt  = r_adr;
          w_state_nxt = S_RESP;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
`endif
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_stb_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      ack_o    <= 1'b0;
      dat_o    <= '0;
      ch_stb_o <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      ack_o    <= w_ack_nxt;
      dat_o    <= w_dat_nxt;
      ch_stb_o <= w_stb_nxt;
    end
  end

`ifdef SPMMIO_XBAR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timer   <= '0;
      r_adr     <= '0;
      err_o     <= 1'b0;
      err_count <= '0;
      err_adr   <= '0;
    end else begin
      r_timer   <= w_timer_nxt;
      r_adr     <= w_adr_nxt;
      err_o     <= w_err_nxt;
      err_count <= w_cnt_nxt;
      err_adr   <= w_eadr_nxt;
    end
  end
`else
  assign err_o     = 1'b0;
  assign err_count = '0;
  assign err_adr   = '0;
`endif

endmodule

// File: tb/tb_spmmio_xbar.sv
// Directed self-checking bench for spmmio_xbar (8 channels, channel 7 masked off, 16-cycle timeout).
module tb_spmmio_xbar;
  localparam int NCH = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [0:23]       adr_i;
  logic              stb_i, cyc_i, we_i;
  logic [3:0]        sel_i;
  logic [31:0]       dat_i;
  logic              ack_o, err_o;
  logic [31:0]       dat_o;
  logic [0:NCH-1]    ch_stb_o;
  logic [NCH-1:0]    ch_ack_i;
  logic [32*NCH-1:0] ch_dat_i;
  logic [15:0]       err_count;
  logic [0:23]       err_adr;
  logic [0:NCH-1]    stb_seen;

  int n_checks = 0;
  int n_errors = 0;

  spmmio_xbar #(
    .NUM_CH(NCH), .DEC_BITS(8), .CH_MASK(16'hFF7F),
    .TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .reset(reset), .adr_i(adr_i), .stb_i(stb_i), .cyc_i(cyc_i),
    .sel_i(sel_i), .we_i(we_i), .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o),
    .err_o(err_o), .ch_stb_o(ch_stb_o), .ch_ack_i(ch_ack_i), .ch_dat_i(ch_dat_i),
    .err_count(err_count), .err_adr(err_adr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [23:0] adr, input logic we);
    adr_i = adr;
    we_i  = we;
    cyc_i = 1'b1;
    stb_i = 1'b1;
  endtask

  task automatic release_bus;
    cyc_i    = 1'b0;
    stb_i    = 1'b0;
    ch_ack_i = '0;
  endtask

  initial begin
    reset = 1'b0; adr_i = '0; we_i = 1'b0; sel_i = 4'hF; dat_i = '0;
    ch_ack_i = '0; ch_dat_i = '0;
    start(24'h010000, 1'b0);
    tick; tick; tick;
    check("rst_ack", 32'(ack_o), 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_stb", 32'(ch_stb_o), 32'h0);
    check("rst_cnt", 32'(err_count), 32'h0);
    check("rst_eadr", 32'(err_adr), 32'h0);
    release_bus;
    reset = 1'b1;
    tick;

    // read ch1, combinational slave ack
    ch_dat_i[32*1 +: 32] = 32'h12345678;
    start(24'h010000, 1'b0);
    tick;
    check("rd1_stb", 32'(ch_stb_o), 32'(8'b0100_0000));
    check("rd1_ack_early", 32'(ack_o), 32'h0);
    ch_ack_i[1] = 1'b1;
    tick;
    check("rd1_ack", 32'(ack_o), 32'h1);
    check("rd1_dat", dat_o, 32'h12345678);
    check("rd1_err", 32'(err_o), 32'h0);
    check("rd1_stb_off", 32'(ch_stb_o), 32'h0);
    release_bus;
    tick;
    check("rd1_ack_pulse", 32'(ack_o), 32'h0);
    check("rd1_dat_hold", dat_o, 32'h12345678);

    // write ch3, slave waits 5 cycles
    ch_dat_i[32*3 +: 32] = 32'hCAFE0003;
    dat_i = 32'hA5A5A5A5;
    start(24'h030000, 1'b1);
    tick;
    stb_seen = '0;
    for (int i = 0; i < 5; i++) begin
      stb_seen |= ch_stb_o;
      check("wr3_stb_held", 32'(ch_stb_o), 32'(8'b0001_0000));
      check("wr3_no_ack", 32'(ack_o), 32'h0);
      if (i < 4) tick;
    end
    ch_ack_i[3] = 1'b1;
    tick;
    stb_seen |= ch_stb_o;
    check("wr3_ack", 32'(ack_o), 32'h1);
    check("wr3_dat", dat_o, 32'hCAFE0003);
    release_bus;
    tick;
    stb_seen |= ch_stb_o;
    check("wr3_ack_pulse", 32'(ack_o), 32'h0);
    check("wr3_stray_stb", 32'(stb_seen), 32'(8'b0001_0000));

    // unmapped indices: beyond NUM_CH, exactly NUM_CH, and masked ch7
    start(24'h0A0000, 1'b0);
    tick;
    check("um0A_ack", 32'(ack_o), 32'h1);
    check("um0A_dat", dat_o, 32'h0);
    check("um0A_stb", 32'(ch_stb_o), 32'h0);
    release_bus;
    tick;
    check("um0A_ack_pulse", 32'(ack_o), 32'h0);
    start(24'h080000, 1'b0);
    tick;
    check("um08_ack", 32'(ack_o), 32'h1);
    check("um08_stb", 32'(ch_stb_o), 32'h0);
    release_bus;
    tick;
    start(24'h070000, 1'b0);
    tick;
    check("um07_ack", 32'(ack_o), 32'h1);
    check("um07_stb", 32'(ch_stb_o), 32'h0);
    tick;
    check("um07_no_reaccept_ack", 32'(ack_o), 32'h0);
    check("um07_no_reaccept_stb", 32'(ch_stb_o), 32'h0);
    release_bus;
    tick;
    check("um07_idle_ack", 32'(ack_o), 32'h0);

`ifdef SPMMIO_XBAR_TIMEOUT_EN
    // ch2 never acks: timeout after 16 BUSY cycles
    start(24'h020004, 1'b0);
    tick;
    for (int i = 1; i < 16; i++) begin
      tick;
      check("to_wait_ack", 32'(ack_o), 32'h0);
    end
    tick;
    check("to_ack", 32'(ack_o), 32'h1);
    check("to_err", 32'(err_o), 32'h1);
    check("to_dat", dat_o, 32'hDEADBEEF);
    check("to_cnt", 32'(err_count), 32'h1);
    check("to_eadr", 32'(err_adr), 32'h020004);
    check("to_stb", 32'(ch_stb_o), 32'h0);
    release_bus;
    tick;
    check("to_ack_pulse", 32'(ack_o), 32'h0);
    check("to_err_pulse", 32'(err_o), 32'h0);
    // ack arrives in the 16th BUSY cycle: slave wins
    ch_dat_i[32*2 +: 32] = 32'h22222222;
    start(24'h020004, 1'b0);
    tick;
    repeat (15) tick;
    ch_ack_i[2] = 1'b1;
    tick;
    check("tolast_ack", 32'(ack_o), 32'h1);
    check("tolast_err", 32'(err_o), 32'h0);
    check("tolast_dat", dat_o, 32'h22222222);
    check("tolast_cnt", 32'(err_count), 32'h1);
    release_bus;
    tick;
`else
    // without timeout a slow slave is waited on indefinitely
    ch_dat_i[32*2 +: 32] = 32'h22222222;
    start(24'h020004, 1'b0);
    tick;
    repeat (40) tick;
    check("slow_stb", 32'(ch_stb_o), 32'(8'b0010_0000));
    check("slow_no_ack", 32'(ack_o), 32'h0);
    check("slow_no_err", 32'(err_o), 32'h0);
    ch_ack_i[2] = 1'b1;
    tick;
    check("slow_ack", 32'(ack_o), 32'h1);
    check("slow_dat", dat_o, 32'h22222222);
    check("slow_err", 32'(err_o), 32'h0);
    check("slow_cnt", 32'(err_count), 32'h0);
    check("slow_eadr", 32'(err_adr), 32'h0);
    release_bus;
    tick;
`endif

    // abort: cyc_i dropped in BUSY cycle 3
    start(24'h060000, 1'b0);
    tick;
    check("ab_stb", 32'(ch_stb_o), 32'(8'b0000_0010));
    tick; tick;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    tick;
    check("ab_stb_off", 32'(ch_stb_o), 32'h0);
    check("ab_no_ack", 32'(ack_o), 32'h0);
    tick;
    check("ab_no_ack2", 32'(ack_o), 32'h0);
    check("ab_no_err", 32'(err_o), 32'h0);

    // reset mid-BUSY
    start(24'h010000, 1'b0);
    tick;
    check("rb_stb", 32'(ch_stb_o), 32'(8'b0100_0000));
    tick;
    reset = 1'b0;
    tick;
    check("rb_stb_off", 32'(ch_stb_o), 32'h0);
    check("rb_ack", 32'(ack_o), 32'h0);
    check("rb_dat", dat_o, 32'h0);
    check("rb_err", 32'(err_o), 32'h0);
    check("rb_cnt", 32'(err_count), 32'h0);
    check("rb_eadr", 32'(err_adr), 32'h0);
    release_bus;
    reset = 1'b1;
    tick;

    // ack on non-selected ch5 while ch4 is busy
    ch_dat_i[32*4 +: 32] = 32'h44444444;
    ch_dat_i[32*5 +: 32] = 32'h55555555;
    start(24'h040000, 1'b0);
    ch_ack_i[5] = 1'b1;
    tick;
    check("x4_stb", 32'(ch_stb_o), 32'(8'b0000_1000));
    tick;
    check("x4_ign5_ack", 32'(ack_o), 32'h0);
    check("x4_ign5_stb", 32'(ch_stb_o), 32'(8'b0000_1000));
    tick;
    check("x4_ign5_ack2", 32'(ack_o), 32'h0);
    ch_ack_i[4] = 1'b1;
    tick;
    check("x4_ack", 32'(ack_o), 32'h1);
    check("x4_dat", dat_o, 32'h44444444);
    release_bus;
    tick;
    check("x4_ack_pulse", 32'(ack_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
